// File: rtl/hex_display_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
//   HEX_W      : width of one displayed digit (one hex nibble).
//   MAX_DIGITS : largest digit count the scanner supports.
//   ANODE_OFF  : all-ones anode pattern (every digit dark); slice to NUM_DIGITS.
package hex_display_scanner_pkg;

    localparam int HEX_W      = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bus bundle between a display controller and hex_display_scanner.
//   enable      : 1 = scan, 0 = dark and frozen
//   value       : HEX_W*NUM_DIGITS value, nibble 0 = rightmost digit
//   load        : single-cycle capture request for value
//   blank_lz    : suppress leading zero digits
//   hex_digit   : nibble of the lit digit, to the segment decoder
//   anode_n     : active-low digit enables
//   load_ack    : pulse when a pending value reaches the display
//   frame_start : pulse when digit 0 becomes the active digit
// master drives the control side; slave is the scanner.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);

    logic                                                  enable;
    logic [hex_display_scanner_pkg::HEX_W*NUM_DIGITS-1:0]  value;
    logic                                                  load;
    logic                                                  blank_lz;
    logic [hex_display_scanner_pkg::HEX_W-1:0]             hex_digit;
    logic [NUM_DIGITS-1:0]                                 anode_n;
    logic                                                  load_ack;
    logic                                                  frame_start;

    modport master (
        output enable, value, load, blank_lz,
        input  hex_digit, anode_n, load_ack, frame_start
    );

    modport slave (
        input  enable, value, load, blank_lz,
        output hex_digit, anode_n, load_ack, frame_start
    );

endinterface

// File: rtl/hex_display_scanner_refresh_divider.sv
// Digit refresh divider: emits a one-cycle tick every REFRESH_DIV enabled
// clock cycles. The count freezes while enable is low so a paused digit
// resumes with its remaining hold time.
//   clk, rst_n : clock and asynchronous active-low reset
//   enable     : count only while high
//   tick       : high on the last cycle of each hold period
module refresh_divider #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    // A divide-by-one still needs a one-bit counter to keep widths legal.
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick = enable && (div_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (div_cnt == LAST_CNT) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed NUM_DIGITS-digit seven-segment scanner.
// Shows one nibble of the committed value at a time, with matching
// active-low anode enable. New values are staged in a pending register and
// only copied to the displayed shadow register on the frame-boundary tick,
// so a frame never mixes old and new digits.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : hex_display_scanner_if slave (enable, value, load, blank_lz,
//                hex_digit, anode_n, load_ack, frame_start)
module hex_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hex_display_scanner_if.slave   bus
);

    import hex_display_scanner_pkg::*;

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int VAL_W   = HEX_W * NUM_DIGITS;
    localparam int SHIFT_W = IDX_W + $clog2(HEX_W);

    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODES_DARK = ANODE_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_0   = NUM_DIGITS'(1);

    logic                  tick;
    logic [IDX_W-1:0]      digit_idx;
    logic [IDX_W-1:0]      idx_next;
    logic [VAL_W-1:0]      pending;
    logic                  pending_vld;
    logic [VAL_W-1:0]      shadow;
    logic [VAL_W-1:0]      shadow_next;
    logic                  frame_wrap;
    logic                  commit;
    logic [SHIFT_W-1:0]    shift_amt;
    logic [VAL_W-1:0]      shifted;
    logic                  blank_next;
    logic [HEX_W-1:0]      nibble_next;
    logic [NUM_DIGITS-1:0] anode_next;

    logic [HEX_W-1:0]      hex_digit_q;
    logic [NUM_DIGITS-1:0] anode_n_q;
    logic                  load_ack_q;
    logic                  frame_start_q;

    refresh_divider #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (bus.enable),
        .tick   (tick)
    );

    // Next digit index and next shadow value. The output registers are fed
    // from these so that the lit digit reflects the post-tick state, and a
    // freshly committed value is visible starting with digit 0.
    always_comb begin
        frame_wrap  = tick && (digit_idx == LAST_IDX);
        commit      = frame_wrap && pending_vld;
        idx_next    = digit_idx;
        if (tick) begin
            idx_next = frame_wrap ? '0 : digit_idx + 1'b1;
        end
        shadow_next = commit ? pending : shadow;
    end

    // Digit select and leading-zero blanking. Shifting the selected nibble
    // down to bit 0 leaves exactly nibbles idx..NUM_DIGITS-1 in the vector,
    // so "all of it is zero" is the leading-zero test. Digit 0 always stays
    // lit so an all-zero value still shows a single 0.
    always_comb begin
        shift_amt   = SHIFT_W'(idx_next) * SHIFT_W'(HEX_W);
        shifted     = shadow_next >> shift_amt;
        nibble_next = shifted[HEX_W-1:0];
        blank_next  = bus.blank_lz && (idx_next != '0) && (shifted == '0);
        anode_next  = blank_next ? ANODES_DARK : ~(ONE_HOT_0 << idx_next);
    end

    // Scan position, load staging and commit. A load in the commit cycle
    // lands in pending after the old pending has been copied out, so it
    // stays valid for the next frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx   <= '0;
            pending     <= '0;
            pending_vld <= 1'b0;
            shadow      <= '0;
        end else begin
            digit_idx <= idx_next;
            if (bus.load) begin
                pending     <= bus.value;
                pending_vld <= 1'b1;
            end else if (commit) begin
                pending_vld <= 1'b0;
            end
            if (commit) begin
                shadow <= pending;
            end
        end
    end

    // Registered display outputs. With enable low every anode goes dark on
    // the next cycle while the scan position is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_digit_q   <= '0;
            anode_n_q     <= ANODES_DARK;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hex_digit_q   <= nibble_next;
            anode_n_q     <= bus.enable ? anode_next : ANODES_DARK;
            load_ack_q    <= commit;
            frame_start_q <= frame_wrap;
        end
    end

    assign bus.hex_digit   = hex_digit_q;
    assign bus.anode_n     = anode_n_q;
    assign bus.load_ack    = load_ack_q;
    assign bus.frame_start = frame_start_q;

endmodule
